// File: rtl/sram_access_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: per-requester req/gnt
// handshake, access attributes, and the shared read-return bus.
interface sram_access_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 20,
    parameter int DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM between the audio engines: one access in
// flight, optional fixed priority for requester 0, round-robin otherwise.
module sram_access_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ACC_CYC = 2,
    parameter int PRIO0   = 1,
    parameter int AW      = 20,
    parameter int DW      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sram_access_arbiter_if.slave   bus,
    output logic [AW-1:0]          o_sram_addr,
    output logic [DW-1:0]          o_sram_wdata,
    output logic                   o_sram_dq_oe,
    output logic                   o_sram_we_n,
    output logic                   o_sram_oe_n,
    input  logic [DW-1:0]          i_sram_rdata
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(ACC_CYC);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [PW-1:0]  ptr, win, arb_idx;
    logic           arb_hit, prio_hit, last;
    logic           cur_we;
    logic [AW-1:0]  cur_addr;
    logic [DW-1:0]  cur_wdata, rdata_q;
    logic [N_REQ-1:0] rvalid_q;
    int             k;

    assign last = (cnt == CW'(ACC_CYC - 1));

    // Requester 0 may pre-empt the rotation; otherwise search from ptr
    always_comb begin
        arb_hit  = 1'b0;
        prio_hit = 1'b0;
        arb_idx  = '0;
        k        = 0;
        if (PRIO0 != 0 && bus.req[0]) begin
            arb_hit  = 1'b1;
            prio_hit = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                k = int'(ptr) + i;
                if (k >= N_REQ) k = k - N_REQ;
                if (!arb_hit && bus.req[k]) begin
                    arb_hit = 1'b1;
                    arb_idx = PW'(k);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            win       <= '0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rvalid_q <= '0;
            if (state == IDLE && arb_hit) begin
                win       <= arb_idx;
                cur_we    <= bus.we[arb_idx];
                cur_addr  <= bus.addr[int'(arb_idx)*AW +: AW];
                cur_wdata <= bus.wdata[int'(arb_idx)*DW +: DW];
                if (!prio_hit)
                    ptr <= (arb_idx == PW'(N_REQ - 1)) ? '0
                                                       : arb_idx + PW'(1);
            end
            if (state == ACCESS && last && !cur_we) begin
                rdata_q       <= i_sram_rdata;
                rvalid_q[win] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (arb_hit) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (last) state_d = IDLE;
                else      cnt_d   = cnt + CW'(1);
            end
        endcase
    end

    // Write strobe drops in the final cycle so data holds past we_n rise
    always_comb begin
        bus.gnt = '0;
        if (state == ACCESS && cnt == '0)
            bus.gnt[win] = 1'b1;
        o_sram_dq_oe = (state == ACCESS) && cur_we;
        o_sram_we_n  = !((state == ACCESS) && cur_we && !last);
        o_sram_oe_n  = !((state == ACCESS) && !cur_we);
    end

    assign bus.busy     = (state == ACCESS);
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign o_sram_addr  = cur_addr;
    assign o_sram_wdata = cur_wdata;
endmodule
